// File: rtl/bf16_accumulate.sv
// Accumulates N_TERMS bfloat16 products through an align/add/normalize FSM and emits the sum.
// Define BF16_ACC_RNE_EN for round-to-nearest-even; the default build truncates.
module bf16_accumulate #(
   parameter int N_TERMS = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] out,
   output logic        out_valid
);

   // state | meaning
   // IDLE  | waiting for a product, in_ready high
   // ALIGN | align accumulator and operand mantissas, classify specials
   // ADD   | signed-magnitude add/subtract of the aligned mantissas
   // NORM  | normalize, round, write accumulator or emit the window
   typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

   localparam int CW = $clog2(N_TERMS + 1);
   localparam logic [CW-1:0] N_LAST = CW'(N_TERMS - 1);

   state_t          state;
   logic [15:0]     acc;
   logic [15:0]     op;
   logic [CW-1:0]   cnt;
   logic [10:0]     ma, mb;
   logic            sa, sb;
   logic [7:0]      exp_max;
   logic            spec_nan, spec_inf, spec_sign;
   logic [11:0]     sum;
   logic            sum_sign;

   // Right shift with every bit pushed past the LSB folded into the sticky position.
   function automatic logic [10:0] shift_sticky(input logic [10:0] m, input logic [7:0] d);
      logic [21:0] w;
      if (d >= 8'd11) begin
         shift_sticky = {10'd0, |m};
      end else begin
         w = {m, 11'd0} >> d;
         shift_sticky = {w[21:12], w[11] | (|w[10:0])};
      end
   endfunction

   logic [7:0]  a_exp, o_exp, e_big;
   logic [10:0] m_a, m_o, al_a, al_o;
   logic        a_inf, o_inf, a_nan, o_nan;
   logic        c_nan, c_inf, c_inf_sign;

   always_comb begin
      a_exp = acc[14:7];
      o_exp = op[14:7];
      m_a   = (a_exp == 8'd0) ? 11'd0 : {1'b1, acc[6:0], 3'b000};
      m_o   = (o_exp == 8'd0) ? 11'd0 : {1'b1, op[6:0], 3'b000};
      a_inf = (a_exp == 8'hFF) && (acc[6:0] == 7'd0);
      o_inf = (o_exp == 8'hFF) && (op[6:0] == 7'd0);
      a_nan = (a_exp == 8'hFF) && (acc[6:0] != 7'd0);
      o_nan = (o_exp == 8'hFF) && (op[6:0] != 7'd0);
      c_nan = a_nan | o_nan | (a_inf & o_inf & (acc[15] != op[15]));
      c_inf = a_inf | o_inf;
      c_inf_sign = a_inf ? acc[15] : op[15];
      if (a_exp >= o_exp) begin
         e_big = a_exp;
         al_a  = m_a;
         al_o  = shift_sticky(m_o, a_exp - o_exp);
      end else begin
         e_big = o_exp;
         al_a  = shift_sticky(m_a, o_exp - a_exp);
         al_o  = m_o;
      end
   end

   logic [11:0] sum_c;
   logic        sum_sign_c;

   always_comb begin
      sum_c      = 12'd0;
      sum_sign_c = sa;
      if (sa == sb) begin
         sum_c = {1'b0, ma} + {1'b0, mb};
      end else if (ma >= mb) begin
         sum_c = {1'b0, ma} - {1'b0, mb};
      end else begin
         sum_c      = {1'b0, mb} - {1'b0, ma};
         sum_sign_c = sb;
      end
   end

   logic [3:0]  lz;
   logic [10:0] m_n;
   logic [9:0]  e_n, e_r;
   logic [7:0]  mant;
   logic [15:0] res;

   always_comb begin
      lz = 4'd11;
      for (int i = 0; i < 11; i++) begin
         if (sum[i]) lz = 4'(10 - i);
      end
      if (sum[11]) begin
         m_n = {sum[11:2], sum[1] | sum[0]};
         e_n = {2'b00, exp_max} + 10'd1;
      end else begin
         m_n = sum[10:0] << lz;
         e_n = {2'b00, exp_max} - {6'd0, lz};
      end
   end

`ifdef BF16_ACC_RNE_EN
   logic       rnd;
   logic [8:0] m_r;

   always_comb begin
      rnd = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
      m_r = {1'b0, m_n[10:3]} + {8'd0, rnd};
      if (m_r[8]) begin
         mant = m_r[8:1];
         e_r  = e_n + 10'd1;
      end else begin
         mant = m_r[7:0];
         e_r  = e_n;
      end
   end
`else
   logic unused_grs;

   always_comb begin
      mant = m_n[10:3];
      e_r  = e_n;
   end
   assign unused_grs = ^m_n[2:0] ^ mant[7];
`endif

   // e_r is two's complement: bit 9 marks an exponent that fell below zero.
   always_comb begin
      if (spec_nan)
         res = 16'h7FC0;
      else if (spec_inf)
         res = {spec_sign, 8'hFF, 7'd0};
      else if (sum == 12'd0)
         res = 16'h0000;
      else if (e_r[9] || (e_r == 10'd0))
         res = 16'h0000;
      else if (e_r >= 10'd255)
         res = {sum_sign, 8'hFF, 7'd0};
      else
         res = {sum_sign, e_r[7:0], mant[6:0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out       <= 16'h0000;
         out_valid <= 1'b0;
         acc       <= 16'h0000;
         op        <= 16'h0000;
         cnt       <= '0;
         ma        <= 11'd0;
         mb        <= 11'd0;
         sa        <= 1'b0;
         sb        <= 1'b0;
         exp_max   <= 8'd0;
         spec_nan  <= 1'b0;
         spec_inf  <= 1'b0;
         spec_sign <= 1'b0;
         sum       <= 12'd0;
         sum_sign  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (clear) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            acc      <= 16'h0000;
            cnt      <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (in_valid) begin
                     op       <= in_data;
                     state    <= ALIGN;
                     in_ready <= 1'b0;
                  end
               end
               ALIGN: begin
                  ma        <= al_a;
                  mb        <= al_o;
                  sa        <= acc[15];
                  sb        <= op[15];
                  exp_max   <= e_big;
                  spec_nan  <= c_nan;
                  spec_inf  <= c_inf;
                  spec_sign <= c_inf_sign;
                  state     <= ADD;
               end
               ADD: begin
                  sum      <= sum_c;
                  sum_sign <= sum_sign_c;
                  state    <= NORM;
               end
               NORM: begin
                  if (cnt == N_LAST) begin
                     out       <= res;
                     out_valid <= 1'b1;
                     acc       <= 16'h0000;
                     cnt       <= '0;
                  end else begin
                     acc <= res;
                     cnt <= cnt + 1'b1;
                  end
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end
               default: begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bf16_accumulate.sv
// Directed-vector bench for bf16_accumulate with a 3-term window.
module tb_bf16_accumulate;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out;
   logic        out_valid;

   int checks = 0;
   int errors = 0;

   bf16_accumulate #(.N_TERMS(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transfer one term and confirm in_ready stays low for exactly three cycles.
   task automatic send_term(input logic [15:0] d);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!in_ready && n < 20) begin
         chk("busy_no_valid", {31'd0, out_valid}, 32'd0);
         tick();
         n++;
      end
      chk("busy_cycles", n, 32'd3);
   endtask

   task automatic run_window(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] want);
      send_term(a);
      send_term(b);
      send_term(c);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_out"}, {16'd0, out}, {16'd0, want});
      tick();
      chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_hold"}, {16'd0, out}, {16'd0, want});
   endtask

   initial begin
      reset    = 1'b1;
      clear    = 1'b0;
      in_data  = 16'h0000;
      in_valid = 1'b0;
      #12;
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out", {16'd0, out}, 32'h0000);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      reset = 1'b0;
      tick();

      run_window("sum6", 16'h3F80, 16'h4000, 16'h4040, 16'h40C0);
      run_window("cancel", 16'h4040, 16'hC040, 16'h0000, 16'h0000);
      run_window("ovf", 16'h7F7F, 16'h7F7F, 16'h0000, 16'h7F80);
      run_window("nan", 16'h7F80, 16'hFF80, 16'h3F80, 16'h7FC0);
`ifdef BF16_ACC_RNE_EN
      run_window("round", 16'h3F80, 16'h3BC0, 16'h0000, 16'h3F81);
`else
      run_window("round", 16'h3F80, 16'h3BC0, 16'h0000, 16'h3F80);
`endif
      run_window("neg", 16'hBF80, 16'hC000, 16'h3F80, 16'hC000);

      send_term(16'h3F80);
      send_term(16'h3F80);
      in_data  = 16'h3F80;
      in_valid = 1'b1;
      clear    = 1'b1;
      tick();
      in_valid = 1'b0;
      clear    = 1'b0;
      chk("clr_ready", {31'd0, in_ready}, 32'd1);
      chk("clr_valid", {31'd0, out_valid}, 32'd0);
      run_window("clr", 16'h3F80, 16'h3F80, 16'h3F80, 16'h4040);

      in_data  = 16'h4000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("arst_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_out", {16'd0, out}, 32'h0000);
      tick();
      reset = 1'b0;
      tick();
      run_window("post_rst", 16'h3F80, 16'h4000, 16'h4040, 16'h40C0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
